// File: rtl/adc_st_pkg.sv
// Shared types and constants for the ADC Avalon-ST packetizer.
// A beat carries 512 bits of data, with sop/eop framing and an empty count.
package adc_st_pkg;

    localparam int unsigned BEAT_W   = 512;
    localparam int unsigned SYMBOL_W = 8;
    localparam int unsigned EMPTY_W  = 6;

    typedef enum logic [1:0] {
        StIdle,
        StCapture,
        StFlush
    } state_e;

    typedef struct packed {
        logic               sop;
        logic               eop;
        logic [EMPTY_W-1:0] empty;
        logic [BEAT_W-1:0]  data;
    } beat_t;

endpackage

// File: rtl/adc_st_packetizer_if.sv
// Avalon-ST stream bundle (readyLatency 0) between the packetizer and its sink.
// The master is the source; the slave drives only st_ready.
interface adc_st_packetizer_if;
    import adc_st_pkg::*;

    logic [BEAT_W-1:0]  st_data;
    logic               st_valid;
    logic               st_ready;
    logic               st_startofpacket;
    logic               st_endofpacket;
    logic [EMPTY_W-1:0] st_empty;

    modport master (
        output st_data,
        output st_valid,
        output st_startofpacket,
        output st_endofpacket,
        output st_empty,
        input  st_ready
    );

    modport slave (
        input  st_data,
        input  st_valid,
        input  st_startofpacket,
        input  st_endofpacket,
        input  st_empty,
        output st_ready
    );

endinterface

// File: rtl/adc_st_beat_fifo.sv
// Show-ahead beat FIFO with a registered head: a beat written at one edge is visible
// on the output after the next edge. Total occupancy (memory plus head) never exceeds DEPTH.
module adc_st_beat_fifo
    import adc_st_pkg::*;
#(
    parameter int unsigned  DEPTH  = 64,
    localparam int unsigned FREE_W = $clog2(DEPTH) + 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_push,
    input  beat_t             i_wdata,
    input  logic              i_pop,
    output beat_t             o_rdata,
    output logic              o_valid,
    output logic [FREE_W-1:0] o_free_slots
);

    localparam int unsigned AW = $clog2(DEPTH);

    beat_t             r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [FREE_W-1:0] r_cnt;
    beat_t             r_out;
    logic              r_out_vld;
    logic              w_pop;
    logic              w_load;

    assign w_pop  = i_pop & r_out_vld;
    // Refill the head whenever it is empty or being consumed this cycle.
    assign w_load = (r_cnt != '0) & (~r_out_vld | w_pop);

    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_cnt     <= '0;
            r_out     <= '0;
            r_out_vld <= 1'b0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_load) begin
                r_out     <= r_mem[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + AW'(1);
                r_out_vld <= 1'b1;
            end else if (w_pop) begin
                r_out_vld <= 1'b0;
            end
            r_cnt <= r_cnt + FREE_W'(i_push) - FREE_W'(w_load);
        end
    end

    assign o_rdata      = r_out;
    assign o_valid      = r_out_vld;
    assign o_free_slots = FREE_W'(DEPTH) - r_cnt - FREE_W'(r_out_vld);

endmodule

// File: rtl/adc_st_packetizer.sv
// Packs a triggered burst of ADC samples into 512-bit Avalon-ST beats with sop/eop/empty.
// A trigger is accepted only when the whole packet already fits in the output FIFO.
module adc_st_packetizer
    import adc_st_pkg::*;
#(
    parameter int unsigned SAMPLE_W   = 16,
    parameter int unsigned FIFO_DEPTH = 64,
    parameter int unsigned NSAMP_W    = 16
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [NSAMP_W-1:0]  i_cfg_nsamples,
    input  logic                i_trig,
    input  logic [SAMPLE_W-1:0] i_sample_data,
    input  logic                i_sample_valid,
    adc_st_packetizer_if.master st_if,
    output logic                o_busy,
    output logic [15:0]         o_trig_drop_count
);

    localparam int unsigned BS             = BEAT_W / SAMPLE_W;
    localparam int unsigned IDX_W          = (BS > 1) ? $clog2(BS) : 1;
    localparam int unsigned FILL_W         = IDX_W + 1;
    localparam int unsigned FREE_W         = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned BN_W           = NSAMP_W + 1;
    localparam int unsigned SYM_PER_SAMPLE = SAMPLE_W / SYMBOL_W;

    state_e                      r_state;
    state_e                      w_state_next;
    logic [BS-1:0][SAMPLE_W-1:0] r_pack;
    logic [BS-1:0][SAMPLE_W-1:0] w_pack_next;
    logic [FILL_W-1:0]           r_fill;
    logic [FILL_W-1:0]           w_fill_inc;
    logic [IDX_W-1:0]            w_slot;
    logic [NSAMP_W-1:0]          r_remaining;
    logic                        r_first;
    beat_t                       r_stage;
    logic                        r_stage_vld;
    logic [15:0]                 r_drop;
    logic [FREE_W-1:0]           w_free;
    logic [BN_W-1:0]             w_beats_needed;
    logic                        w_idle;
    logic                        w_capture;
    logic                        w_accept;
    logic                        w_drop;
    logic                        w_take;
    logic                        w_last;
    logic                        w_stage;
    beat_t                       w_fifo_out;
    logic                        w_fifo_valid;

    // FSM: state register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:    if (w_accept) w_state_next = StCapture;
            StCapture: if (w_take && w_last) w_state_next = StFlush;
            StFlush:   w_state_next = StIdle;
            default:   w_state_next = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        w_idle    = 1'b0;
        w_capture = 1'b0;
        unique case (r_state)
            StIdle:    w_idle = 1'b1;
            StCapture: w_capture = 1'b1;
            default:   ;
        endcase
    end

    assign o_busy = ~w_idle;

    assign w_beats_needed = ({1'b0, i_cfg_nsamples} + BN_W'(BS - 1)) / BN_W'(BS);
    assign w_accept = w_idle & i_trig & (i_cfg_nsamples != '0)
                    & (32'(w_beats_needed) <= 32'(w_free));
    assign w_drop   = i_trig & ~w_accept;
    assign w_take   = w_capture & i_sample_valid;
    assign w_last   = (r_remaining == NSAMP_W'(1));

    assign w_fill_inc = r_fill + FILL_W'(1);
    assign w_stage    = w_take & (w_last | (w_fill_inc == FILL_W'(BS)));
    // Slot BS-1 is the high-order end, so the first sample of a beat lands in the top bits.
    assign w_slot     = IDX_W'(BS - 1) - r_fill[IDX_W-1:0];

    always_comb begin
        w_pack_next         = r_pack;
        w_pack_next[w_slot] = i_sample_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pack      <= '0;
            r_fill      <= '0;
            r_remaining <= '0;
            r_first     <= 1'b0;
            r_stage     <= '0;
            r_stage_vld <= 1'b0;
            r_drop      <= '0;
        end else begin
            r_stage_vld <= w_stage;
            if (w_accept) begin
                r_remaining <= i_cfg_nsamples;
                r_fill      <= '0;
                r_pack      <= '0;
                r_first     <= 1'b1;
            end else if (w_take) begin
                r_remaining <= r_remaining - NSAMP_W'(1);
                if (w_stage) begin
                    r_stage.sop   <= r_first;
                    r_stage.eop   <= w_last;
                    r_stage.empty <= w_last
                        ? EMPTY_W'((BS - 32'(w_fill_inc)) * SYM_PER_SAMPLE) : '0;
                    r_stage.data  <= w_pack_next;
                    r_pack        <= '0;
                    r_fill        <= '0;
                    r_first       <= 1'b0;
                end else begin
                    r_pack <= w_pack_next;
                    r_fill <= w_fill_inc;
                end
            end
            if (w_drop && (r_drop != 16'hFFFF)) begin
                r_drop <= r_drop + 16'd1;
            end
        end
    end

    assign o_trig_drop_count = r_drop;

    // Space was reserved at trigger time, so the staged beat is pushed unconditionally.
    adc_st_beat_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_push       (r_stage_vld),
        .i_wdata      (r_stage),
        .i_pop        (w_fifo_valid & st_if.st_ready),
        .o_rdata      (w_fifo_out),
        .o_valid      (w_fifo_valid),
        .o_free_slots (w_free)
    );

    assign st_if.st_data          = w_fifo_out.data;
    assign st_if.st_valid         = w_fifo_valid;
    assign st_if.st_startofpacket = w_fifo_out.sop;
    assign st_if.st_endofpacket   = w_fifo_out.eop;
    assign st_if.st_empty         = w_fifo_out.empty;

endmodule

// File: tb/tb_adc_st_packetizer.sv
// Bench for adc_st_packetizer: a queue of expected beats built from packet-level rules,
// checked against every transferred beat, plus literal pins on latency, framing and drops.
module tb_adc_st_packetizer;
    import adc_st_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cfg = '0;
    logic        trig = 1'b0;
    logic        sval = 1'b0;
    logic [15:0] sdat = '0;
    logic        ready = 1'b1;
    logic        busy;
    logic [15:0] drop;

    logic [15:0] s_cfg = '0;
    logic        s_trig = 1'b0;
    logic        s_sval = 1'b0;
    logic [15:0] s_sdat = '0;
    logic        s_busy;
    logic [15:0] s_drop;

    int          n_tests = 0;
    int          n_fail = 0;
    beat_t       exp_q[$];
    beat_t       got_q[$];
    beat_t       m_beat;
    beat_t       s_beat;
    beat_t       prev_beat;
    beat_t       cmp_exp;
    beat_t       saved;
    bit          prev_stall = 1'b0;

    always #5 clk = ~clk;

    adc_st_packetizer_if m_if ();
    adc_st_packetizer_if s_if ();

    assign m_if.st_ready = ready;
    assign s_if.st_ready = 1'b0;
    assign m_beat = {m_if.st_startofpacket, m_if.st_endofpacket, m_if.st_empty, m_if.st_data};
    assign s_beat = {s_if.st_startofpacket, s_if.st_endofpacket, s_if.st_empty, s_if.st_data};

    adc_st_packetizer #(
        .SAMPLE_W   (16),
        .FIFO_DEPTH (64),
        .NSAMP_W    (16)
    ) u_dut (
        .i_clk             (clk),
        .i_reset           (rst),
        .i_cfg_nsamples    (cfg),
        .i_trig            (trig),
        .i_sample_data     (sdat),
        .i_sample_valid    (sval),
        .st_if             (m_if),
        .o_busy            (busy),
        .o_trig_drop_count (drop)
    );

    adc_st_packetizer #(
        .SAMPLE_W   (16),
        .FIFO_DEPTH (4),
        .NSAMP_W    (16)
    ) u_small (
        .i_clk             (clk),
        .i_reset           (rst),
        .i_cfg_nsamples    (s_cfg),
        .i_trig            (s_trig),
        .i_sample_data     (s_sdat),
        .i_sample_valid    (s_sval),
        .st_if             (s_if),
        .o_busy            (s_busy),
        .o_trig_drop_count (s_drop)
    );

    task automatic check(input string name, input logic [511:0] got, input logic [511:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Packet n samples of base+i: 32 samples per beat, first sample in the top 16 bits.
    task automatic model_packet(input int n, input logic [15:0] base);
        int nb;
        nb = (n + 31) / 32;
        for (int b = 0; b < nb; b++) begin
            beat_t e;
            e = '0;
            e.sop = (b == 0);
            e.eop = (b == nb - 1);
            for (int j = 0; j < 32; j++) begin
                if (b * 32 + j < n) e.data[511 - 16 * j -: 16] = base + 16'(b * 32 + j);
            end
            if (e.eop) e.empty = 6'((32 * nb - n) * 2);
            exp_q.push_back(e);
        end
    endtask

    task automatic send(input int n, input logic [15:0] base, input bit gaps,
                        input int mid_trig, input int abort_at);
        int i;
        int c;
        bit v;
        i = 0;
        c = 0;
        if (abort_at < 0) model_packet(n, base);
        @(posedge clk); #1;
        cfg = 16'(n); trig = 1'b1; sval = 1'b1; sdat = 16'hDEAD;
        while (i < n && i != abort_at) begin
            @(posedge clk); #1;
            v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            trig = (c == mid_trig);
            sval = v;
            sdat = v ? base + 16'(i) : 16'hBEEF;
            if (v) i++;
            c++;
        end
        @(posedge clk); #1;
        trig = 1'b0; sval = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 600) begin
            @(posedge clk);
            k++;
        end
        repeat (3) @(posedge clk);
        #1;
        check(name, 512'(exp_q.size()), 512'(0));
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall.valid", 512'(m_if.st_valid), 512'(1));
                check("stall.data", m_beat.data, prev_beat.data);
                check("stall.flags", 512'({m_beat.sop, m_beat.eop, m_beat.empty}),
                      512'({prev_beat.sop, prev_beat.eop, prev_beat.empty}));
            end
            if (m_if.st_valid && m_if.st_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got beat top=%0h want no beat",
                             m_beat.data[511:496]);
                end else begin
                    cmp_exp = exp_q.pop_front();
                    check("beat.data", m_beat.data, cmp_exp.data);
                    check("beat.flags", 512'({m_beat.sop, m_beat.eop, m_beat.empty}),
                          512'({cmp_exp.sop, cmp_exp.eop, cmp_exp.empty}));
                    got_q.push_back(m_beat);
                end
            end
            prev_stall = m_if.st_valid && !m_if.st_ready;
            prev_beat  = m_beat;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst.valid", 512'(m_if.st_valid), 512'(0));
        check("rst.busy", 512'(busy), 512'(0));
        check("rst.drop", 512'(drop), 512'(0));
        check("rst.data", m_if.st_data, 512'(0));
        rst = 1'b0;

        // 1: single full beat, plus write-to-valid latency
        send(32, 16'h0000, 1'b0, -1, -1);
        check("t1.lat0", 512'(m_if.st_valid), 512'(0));
        @(posedge clk); #1;
        check("t1.lat1", 512'(m_if.st_valid), 512'(0));
        @(posedge clk); #1;
        check("t1.lat2", 512'(m_if.st_valid), 512'(1));
        wait_drain("t1.drain");
        check("t1.busy", 512'(busy), 512'(0));
        check("t1.sop_eop_empty", 512'({got_q[0].sop, got_q[0].eop, got_q[0].empty}),
              512'({1'b1, 1'b1, 6'd0}));
        check("t1.first", 512'(got_q[0].data[511:496]), 512'(0));
        check("t1.last", 512'(got_q[0].data[15:0]), 512'(31));

        // 2: 40 samples -> full beat plus an 8-sample eop beat
        send(40, 16'h0000, 1'b0, -1, -1);
        wait_drain("t2.drain");
        check("t2.b1flags", 512'({got_q[1].sop, got_q[1].eop, got_q[1].empty}),
              512'({1'b1, 1'b0, 6'd0}));
        check("t2.b2flags", 512'({got_q[2].sop, got_q[2].eop, got_q[2].empty}),
              512'({1'b0, 1'b1, 6'd48}));
        check("t2.b2first", 512'(got_q[2].data[511:496]), 512'(32));
        check("t2.b2low", 512'(got_q[2].data[383:0]), 512'(0));

        // zero-length request is rejected
        @(posedge clk); #1;
        cfg = 16'd0; trig = 1'b1;
        @(posedge clk); #1;
        trig = 1'b0;
        check("t0.busy", 512'(busy), 512'(0));
        check("t0.drop", 512'(drop), 512'(1));

        // 3: three beats with the sink stalled while the first beat is presented
        fork
            send(96, 16'h2000, 1'b0, -1, -1);
            begin
                repeat (30) @(posedge clk);
                #1 ready = 1'b0;
                repeat (10) @(posedge clk);
                #1 ready = 1'b1;
            end
        join
        wait_drain("t3.drain");
        check("t3.count", 512'(got_q.size()), 512'(6));

        // 5: gapped samples and a trigger while capturing
        send(50, 16'h1000, 1'b1, 4, -1);
        wait_drain("t5.drain");
        check("t5.drop", 512'(drop), 512'(2));
        check("t5.b2flags", 512'({got_q[7].sop, got_q[7].eop, got_q[7].empty}),
              512'({1'b0, 1'b1, 6'd28}));

        // 6: reset mid-packet discards it
        send(32, 16'h5500, 1'b0, -1, 10);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t6.valid", 512'(m_if.st_valid), 512'(0));
        check("t6.busy", 512'(busy), 512'(0));
        check("t6.drop", 512'(drop), 512'(0));
        repeat (4) @(posedge clk);
        #1;
        check("t6.empty", 512'(m_if.st_valid), 512'(0));
        send(32, 16'h7700, 1'b0, -1, -1);
        wait_drain("t6.drain");
        check("t6.count", 512'(got_q.size()), 512'(9));
        check("t6.first", 512'(got_q[8].data[511:496]), 512'(16'h7700));
        check("t6.last", 512'(got_q[8].data[15:0]), 512'(16'h771F));

        // 4: depth-4 FIFO, sink never ready
        @(posedge clk); #1;
        s_cfg = 16'd128; s_trig = 1'b1;
        @(posedge clk); #1;
        s_trig = 1'b0;
        check("t4.busy", 512'(s_busy), 512'(1));
        for (int i = 0; i < 128; i++) begin
            s_sval = 1'b1;
            s_sdat = 16'(i);
            @(posedge clk); #1;
        end
        s_sval = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("t4.idle", 512'(s_busy), 512'(0));
        check("t4.valid", 512'(s_if.st_valid), 512'(1));
        check("t4.sop", 512'({s_beat.sop, s_beat.eop}), 512'({1'b1, 1'b0}));
        check("t4.first", 512'(s_beat.data[511:496]), 512'(0));
        check("t4.last", 512'(s_beat.data[15:0]), 512'(31));
        saved = s_beat;
        s_cfg = 16'd1; s_trig = 1'b1;
        @(posedge clk); #1;
        s_trig = 1'b0;
        check("t4.rej_busy", 512'(s_busy), 512'(0));
        repeat (2) @(posedge clk);
        #1;
        check("t4.drop", 512'(s_drop), 512'(1));
        check("t4.hold_data", s_beat.data, saved.data);
        check("t4.hold_valid", 512'(s_if.st_valid), 512'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
